// File: rtl/note_scroller_pkg.sv
// Shared definitions for the note scroller: lane indices, FSM encoding and
// default chart geometry.
package note_scroller_pkg;

  localparam int LANE_RED    = 0;
  localparam int LANE_YELLOW = 1;
  localparam int LANE_BLUE   = 2;

  localparam int DEF_LANES  = 3;
  localparam int DEF_DEPTH  = 100;
  localparam int DEF_WINDOW = 27;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Width needed to hold a step count from 0 up to depth inclusive.
  function automatic int steps_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/note_scroller_if.sv
// Control, chart and status bundle between the chart loader / judge side and
// the note scroller.
interface note_scroller_if
  import note_scroller_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WINDOW = DEF_WINDOW
);

  localparam int SW = steps_w(DEPTH);

  logic                      tick;
  logic                      load;
  logic                      pause;
  logic [LANES*DEPTH-1:0]    chart_in;
  logic [LANES-1:0]          hit;
  logic [LANES*WINDOW-1:0]   window_out;
  logic [LANES-1:0]          hit_ok;
  logic [LANES-1:0]          missed;
  logic                      playing;
  logic                      done;
  logic [SW-1:0]             steps_left;

  modport master (
    output tick, load, pause, chart_in, hit,
    input  window_out, hit_ok, missed, playing, done, steps_left
  );

  modport slave (
    input  tick, load, pause, chart_in, hit,
    output window_out, hit_ok, missed, playing, done, steps_left
  );

endinterface

// File: rtl/note_scroller_lane.sv
// One lane of the chart: a DEPTH-bit scroll register whose MSB is the
// judgement position, with per-lane hit and miss pulses.
module note_lane
  import note_scroller_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             hit,
  input  logic [DEPTH-1:0] chart,
  output logic [DEPTH-1:0] lane_q,
  output logic             hit_ok,
  output logic             missed
);

  logic head;
  logic hit_take;

  assign head     = lane_q[DEPTH-1];
  assign hit_take = hit & head;

  // A hit on the same cycle as a shift needs no explicit clear: the judged
  // bit leaves the register and DEPTH-1 takes DEPTH-2 unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      hit_ok <= 1'b0;
      missed <= 1'b0;
    end else if (load) begin
      lane_q <= chart;
      hit_ok <= 1'b0;
      missed <= 1'b0;
    end else begin
      if (shift) begin
        lane_q <= lane_q << 1;
      end else if (hit_take) begin
        lane_q[DEPTH-1] <= 1'b0;
      end
      hit_ok <= hit_take;
      missed <= shift & head & ~hit;
    end
  end

endmodule

// File: rtl/note_scroller.sv
// Chart scroller: LANES scroll registers advanced on accepted beat ticks, a
// play-length counter and the IDLE/PLAY sequencing with end-of-song pulse.
module note_scroller
  import note_scroller_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic            clk,
  input  logic            reset,
  note_scroller_if.slave  bus
);

  localparam int SW = steps_w(DEPTH);

  state_t          state;
  logic [SW-1:0]   steps_left_q;
  logic            done_q;
  logic            playing;
  logic            acc_tick;
  logic            hit_gate;
  logic [LANES-1:0] hit_ok_v;
  logic [LANES-1:0] missed_v;

  assign playing  = (state == PLAY);
  // load always wins over tick and hit; hits are only judged while playing.
  assign acc_tick = bus.tick & playing & ~bus.pause & ~bus.load;
  assign hit_gate = playing & ~bus.pause & ~bus.load;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DEPTH-1:0] lane_q;

    note_lane #(
      .DEPTH (DEPTH)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (bus.load),
      .shift  (acc_tick),
      .hit    (bus.hit[l] & hit_gate),
      .chart  (bus.chart_in[l*DEPTH +: DEPTH]),
      .lane_q (lane_q),
      .hit_ok (hit_ok_v[l]),
      .missed (missed_v[l])
    );

    assign bus.window_out[l*WINDOW +: WINDOW] = lane_q[DEPTH-1 -: WINDOW];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      steps_left_q <= '0;
      done_q       <= 1'b0;
    end else if (bus.load) begin
      state        <= PLAY;
      steps_left_q <= SW'(DEPTH);
      done_q       <= 1'b0;
    end else if (acc_tick) begin
      // acc_tick implies PLAY, so steps_left_q is at least 1 here.
      steps_left_q <= steps_left_q - 1'b1;
      if (steps_left_q == SW'(1)) begin
        state  <= IDLE;
        done_q <= 1'b1;
      end else begin
        done_q <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.hit_ok     = hit_ok_v;
  assign bus.missed     = missed_v;
  assign bus.playing    = playing;
  assign bus.done       = done_q;
  assign bus.steps_left = steps_left_q;

endmodule

// File: tb/tb_note_scroller.sv
// Directed plus randomized bench for note_scroller against a time-indexed
// chart model (notes addressed by song position rather than by shifting).
module tb_note_scroller;

  localparam int L = 3;
  localparam int D = 8;
  localparam int W = 4;

  logic clk;
  logic reset;

  note_scroller_if #(.LANES(L), .DEPTH(D), .WINDOW(W)) bus ();

  note_scroller #(.LANES(L), .DEPTH(D), .WINDOW(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: m_note[l][i] is the note played at song position i of lane l.
  bit         m_note [L][D];
  int         m_pos;
  int         m_steps;
  bit         m_playing;
  logic [L-1:0] e_hok;
  logic [L-1:0] e_mis;
  bit         e_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [L*W-1:0] exp_window();
    logic [L*W-1:0] w;
    w = '0;
    for (int l = 0; l < L; l++)
      for (int k = 0; k < W; k++)
        if (m_pos + k < D) w[l*W + W-1-k] = m_note[l][m_pos + k];
    return w;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < L; l++)
      for (int i = 0; i < D; i++) m_note[l][i] = 1'b0;
    m_pos = 0; m_steps = 0; m_playing = 1'b0;
    e_hok = '0; e_mis = '0; e_done = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".window"},  32'(bus.window_out), 32'(exp_window()));
    chk({tag, ".hit_ok"},  32'(bus.hit_ok),     32'(e_hok));
    chk({tag, ".missed"},  32'(bus.missed),     32'(e_mis));
    chk({tag, ".playing"}, 32'(bus.playing),    32'(m_playing));
    chk({tag, ".done"},    32'(bus.done),       32'(e_done));
    chk({tag, ".steps"},   32'(bus.steps_left), 32'(m_steps));
  endtask

  task automatic cycle(input string tag, input bit t, input bit ld, input bit ps,
                       input logic [L-1:0] h, input logic [L*D-1:0] ch);
    bit acc;
    logic [L-1:0] hv;
    bit head;
    bus.tick = t; bus.load = ld; bus.pause = ps; bus.hit = h; bus.chart_in = ch;
    if (ld) begin
      for (int l = 0; l < L; l++)
        for (int i = 0; i < D; i++) m_note[l][i] = ch[l*D + D-1-i];
      m_pos = 0; m_steps = D; m_playing = 1'b1;
      e_hok = '0; e_mis = '0; e_done = 1'b0;
    end else begin
      acc = t && m_playing && !ps;
      hv  = (m_playing && !ps) ? h : '0;
      for (int l = 0; l < L; l++) begin
        head = (m_pos < D) ? m_note[l][m_pos] : 1'b0;
        e_hok[l] = hv[l] & head;
        e_mis[l] = acc & head & ~hv[l];
        if (e_hok[l]) m_note[l][m_pos] = 1'b0;
      end
      e_done = 1'b0;
      if (acc) begin
        m_pos++;
        m_steps--;
        if (m_steps == 0) begin
          m_playing = 1'b0;
          e_done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
    bus.tick = 1'b0; bus.load = 1'b0; bus.hit = '0;
  endtask

  initial begin
    logic [L*D-1:0] ch;
    bus.tick = 1'b0; bus.load = 1'b0; bus.pause = 1'b0;
    bus.hit = '0; bus.chart_in = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Plan 1: load red 1010_0000
    ch = '0; ch[7:0] = 8'b1010_0000;
    cycle("load1", 1'b0, 1'b1, 1'b0, '0, ch);
    chk("load1.red_win", 32'(bus.window_out[W-1:0]), 32'h0000000a);
    chk("load1.steps8", 32'(bus.steps_left), 32'd8);

    // Plan 2: eight ticks, no hits
    for (int i = 1; i <= D; i++) begin
      cycle($sformatf("tick%0d", i), 1'b1, 1'b0, 1'b0, '0, '0);
      if (i == 1) chk("tick1.miss_red", 32'(bus.missed), 32'h1);
    end
    chk("end.done", 32'(bus.done), 32'h1);
    cycle("after_end", 1'b1, 1'b0, 1'b0, '0, '0);
    chk("after_end.done", 32'(bus.done), 32'h0);

    // Plan 3: hit with first tick; hit yellow on empty lane
    ch = '0; ch[7:0] = 8'b1000_0000;
    cycle("load3", 1'b0, 1'b1, 1'b0, '0, ch);
    cycle("hit_tick", 1'b1, 1'b0, 1'b0, 3'b001, '0);
    chk("hit_tick.hit_ok", 32'(bus.hit_ok), 32'h1);
    cycle("hit_empty", 1'b0, 1'b0, 1'b0, 3'b010, '0);

    // Plan 4: pause across ticks, then one shift
    ch = {8'b1100_0000, 8'b0110_0000, 8'b1011_0000};
    cycle("load4", 1'b0, 1'b1, 1'b0, '0, ch);
    for (int i = 0; i < 3; i++) cycle("paused", 1'b1, 1'b0, 1'b1, 3'b111, '0);
    chk("paused.steps", 32'(bus.steps_left), 32'd8);
    cycle("unpause", 1'b1, 1'b0, 1'b0, '0, '0);

    // Plan 5: load and tick together mid-song
    cycle("mid", 1'b1, 1'b0, 1'b0, '0, '0);
    ch = {8'b1001_0110, 8'b1111_0000, 8'b1000_0001};
    cycle("load_tick", 1'b1, 1'b1, 1'b0, 3'b111, ch);

    // Plan 6: asynchronous reset between edges
    cycle("pre_rst", 1'b1, 1'b0, 1'b0, '0, '0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle("idle_tick", 1'b1, 1'b0, 1'b0, 3'b111, '0);

    // Randomized play
    for (int n = 0; n < 400; n++) begin
      bit t, ld, ps;
      logic [L-1:0] h;
      t  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 29) == 0) || (!m_playing && $urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 6) == 0);
      h  = L'($urandom);
      ch = (L*D)'($urandom);
      cycle("rand", t, ld, ps, h, ch);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_scroller.md
Name: note_scroller

Overview:
- Parametrised successor of the three-lane note shifter: holds a full song chart per lane, scrolls it one step per beat strobe, and exposes a visible window per lane to the renderer.
- Adds hit consumption at the judgement position, miss detection, pause, a play-length counter and end-of-song signalling.
- Sits between chart ROM/loader and the display/judge logic.

Parameters:
- LANES, 3, number of note lanes (lane 0 = red, 1 = yellow, 2 = blue).
- DEPTH, 100, chart length per lane, in steps.
- WINDOW, 27, visible steps per lane (1 ≤ WINDOW ≤ DEPTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- tick  in  1  one-cycle scroll strobe (beat clock enable).
- load  in  1  one-cycle strobe: capture chart_in and start play.
- pause  in  1  level; while high, tick is ignored.
- chart_in  in  LANES*DEPTH  lane l occupies bits [l*DEPTH +: DEPTH]; bit DEPTH-1 of each lane plays first.
- hit  in  LANES  per-lane strike; clears the note at the judgement position.
- window_out  out  LANES*WINDOW  lane l = chart_reg[l][DEPTH-1 -: WINDOW]; MSB = judgement position.
- hit_ok  out  LANES  registered pulse: hit landed on a note.
- missed  out  LANES  registered pulse: a note left the judgement position unhit.
- playing  out  1  high from the load until the song ends.
- done  out  1  one-cycle pulse at the end of the song.
- steps_left  out  $clog2(DEPTH+1)  ticks remaining.

Behaviour:
- Reset (async): chart regs = 0, steps_left = 0, state = IDLE, and every output = 0.
- States: IDLE and PLAY.
  - IDLE → PLAY on load.
  - PLAY → IDLE when a tick is accepted with steps_left == 1. done pulses the following cycle, playing drops the same cycle, and steps_left = 0.
- load, in any state:
  - chart_reg ← chart_in; steps_left ← DEPTH; playing = 1 the next cycle.
  - hit_ok, missed and done are 0 that cycle.
  - load has priority over tick and hit in the same cycle.
- Accepted tick = tick & playing & ~pause & ~load.
  - Each lane shifts left by 1, LSB filled with 0.
  - steps_left decrements by 1.
- hit[l] in PLAY, no load:
  - If bit DEPTH-1 of lane l is 1: the bit is cleared and hit_ok[l] = 1 next cycle.
  - If the bit is 0: no change, and no hit_ok.
  - hit in IDLE or during pause is ignored. The judge masks it while paused.
- Hit and accepted tick in the same cycle:
  - The hit is evaluated on the pre-shift bit.
  - If it was a note, it is consumed and counts as hit_ok, not a miss.
  - The shifted-in value at DEPTH-1 comes from bit DEPTH-2 unchanged.
- Miss: on an accepted tick, missed[l] = 1 next cycle iff pre-shift bit DEPTH-1 = 1 and hit[l] = 0.
- The final accepted tick (steps_left 1 → 0) also evaluates misses, so the last note can report missed in the same cycle as done.
- hit_ok, missed and done are single-cycle pulses, registered, with latency 1 from the causing cycle.
- window_out is combinational from chart_reg, so it shows the new contents 1 cycle after a shift or load.
- Reset mid-song: immediate return to IDLE with the chart cleared, and no done pulse.
- Arithmetic: steps_left never underflows; accepted ticks require playing, which implies steps_left ≥ 1.

Decomposition:
- Shared package: lane index constants (LANE_RED=0, LANE_YELLOW=1, LANE_BLUE=2), the state encoding (IDLE=1'b0, PLAY=1'b1), and the default DEPTH/WINDOW.
- One sub-module, note_lane. It holds one DEPTH-bit register with shift, load and hit-clear, and produces per-lane hit_ok and missed.
  - note_scroller instantiates LANES copies with a generate loop.
  - The top level owns the FSM, steps_left, done and playing.

Test Plan (LANES=3, DEPTH=8, WINDOW=4 unless noted):
1. Reset, then load with red chart 8'b1010_0000 → next cycle window_out red = 4'b1010, playing = 1, steps_left = 8, done = 0.
2. From 1, issue 8 ticks with no hits → missed[0] pulses after ticks 1 and 3 only. After tick 8: done pulses once, playing = 0, steps_left = 0, window all zero.
3. Load red = 8'b1000_0000, then assert hit[0] together with the first tick → hit_ok[0] = 1 and missed[0] = 0 next cycle. hit[1] alone with yellow = 0 → no hit_ok[1].
4. Hold pause high across 3 ticks → chart and steps_left unchanged. Release pause and tick → one shift.
5. Assert load and tick in the same cycle mid-song → the new chart is loaded unshifted, steps_left = 8, no missed/done pulse.
6. Assert reset asynchronously mid-song (between clock edges) → all outputs 0 immediately. Subsequent ticks have no effect until load.
